// File: rtl/arm_multicycle_controller.sv
// rtl/arm_multicycle_controller.sv - multicycle ARM controller FSM with NZCV flags and memory handshake
module arm_multicycle_controller #(
    parameter int          ALUCTRL_W     = 4,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter logic [3:0]  FLAGS_RESET   = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ImmSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 storedCarry,
    output logic [3:0]           state
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    localparam logic [3:0] CMD_ADD = 4'b0100;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_pc;
    logic       rdy;
    logic [3:0] flags;
    logic       cond_q;
    logic       cond_ex;
    logic       cmd_arith;
    logic       cmd_test;
    logic [3:0] next_state;
    logic [3:0] alu_cmd;
    logic       unused_bits;

    assign cond        = Instr[31:28];
    assign op          = Instr[27:26];
    assign funct       = Instr[25:20];
    assign cmd         = Instr[24:21];
    assign rd_pc       = (Instr[15:12] == 4'hF);
    assign rdy         = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};
    assign storedCarry = flags[1];

    // arithmetic commands own the C and V flags; TST/TEQ/CMP/CMN never write a register
    assign cmd_arith = (cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                    4'b0110, 4'b0111, 4'b1010, 4'b1011});
    assign cmd_test  = (cmd[3:2] == 2'b10);

    // ARM condition evaluation against the stored NZCV flags
    always_comb begin
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    // next-state selection; unused encodings fall back to FETCH
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = rdy ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    2'b00:   next_state = funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: next_state = funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = rdy ? MEMWB : MEMRD;
            MEMWR:  next_state = rdy ? FETCH : MEMWR;
            MEMWB:  next_state = FETCH;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // state, flags and latched condition registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            flags  <= FLAGS_RESET;
            cond_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE)
                cond_q <= cond_ex;
            if ((state == EXECR || state == EXECI) && funct[0] && cond_q) begin
                flags[3:2] <= ALUFlags[3:2];
                if (cmd_arith)
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // per-state datapath controls; strobes gated by cond_q latched in DECODE
    always_comb begin
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_cmd   = CMD_ADD;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                PCWrite   = rdy;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = cond_q;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_q;
                PCWrite   = cond_q & rd_pc;
            end
            EXECR: alu_cmd = cmd;
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_cmd = cmd;
            end
            ALUWB: begin
                RegWrite = cond_q & ~cmd_test;
                PCWrite  = cond_q & ~cmd_test & rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_q;
            end
            default: ;
        endcase
    end

    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign ImmSrc     = op;
    assign ALUControl = ALUCTRL_W'(alu_cmd);

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb/tb_arm_multicycle_controller.sv - scoreboard bench for arm_multicycle_controller
module tb_arm_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        mem_req, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic        ALUSrcA;
    logic [3:0]  ALUControl;
    logic        storedCarry;
    logic [3:0]  state;

    arm_multicycle_controller #(.ALUCTRL_W(4), .MEM_HANDSHAKE(1'b1), .FLAGS_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .storedCarry(storedCarry), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [5:0] wr;   // {mem_req, IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc}
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic exp_c  = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // mux selects {ALUSrcA, ALUSrcB, ResultSrc} expected in each state
    function automatic logic [4:0] mux_of(input logic [3:0] st);
        case (st)
            4'd0: return 5'b1_10_10;
            4'd1: return 5'b1_10_00;
            4'd2: return 5'b0_01_00;
            4'd4: return 5'b0_00_01;
            4'd7: return 5'b0_01_00;
            4'd9: return 5'b0_01_10;
            default: return 5'b0_00_00;
        endcase
    endfunction

    // compare DUT outputs against the expectation queued for this cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".state"}, 16'(state), 16'(e.st));
            check({e.tag, ".strobes"}, 16'({mem_req, IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc}), 16'(e.wr));
            check({e.tag, ".mux"}, 16'({ALUSrcA, ALUSrcB, ResultSrc}), 16'(mux_of(e.st)));
            check({e.tag, ".carry"}, 16'(storedCarry), 16'(e.c));
            check({e.tag, ".immsrc"}, 16'(ImmSrc), 16'(Instr[27:26]));
            if (e.st inside {4'd0, 4'd1, 4'd2, 4'd9})
                check({e.tag, ".aluctl"}, 16'(ALUControl), 16'h4);
            if (e.st inside {4'd6, 4'd7})
                check({e.tag, ".aluctl"}, 16'(ALUControl), 16'(Instr[24:21]));
            if (e.st == 4'd1)
                check({e.tag, ".regsrc"}, 16'(RegSrc), 16'({Instr[27:26] == 2'b01, Instr[27:26] == 2'b10}));
        end
    end

    task automatic cyc(input string tag, input logic [3:0] st, input logic [5:0] wr,
                       input logic mr, input logic [3:0] af);
        exp_t e;
        mem_ready = mr;
        ALUFlags  = af;
        e.tag = tag; e.st = st; e.wr = wr; e.c = exp_c;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; ALUFlags = 4'h0; Instr = 32'hE2810001;
        @(posedge clk); #1;
        cyc("rst_wait", 0, 6'b100000, 0, 4'h0);
        cyc("rst_rdy",  0, 6'b111000, 1, 4'h0);
        reset = 1'b1;

        // ADD R0,R1,#1
        Instr = 32'hE2810001;
        cyc("add_f", 0, 6'b111000, 1, 4'h0);
        cyc("add_d", 1, 6'b000000, 1, 4'h0);
        cyc("add_x", 7, 6'b000000, 1, 4'hF);
        cyc("add_w", 8, 6'b000010, 1, 4'h0);

        // SUBS R0,R0,#1 sets Z and C
        Instr = 32'hE2500001;
        cyc("subs_f", 0, 6'b111000, 1, 4'h0);
        cyc("subs_d", 1, 6'b000000, 1, 4'h0);
        cyc("subs_x", 7, 6'b000000, 1, 4'b0110);
        exp_c = 1'b1;
        cyc("subs_w", 8, 6'b000010, 1, 4'h0);

        // BEQ taken
        Instr = 32'h0A000002;
        cyc("beq_f", 0, 6'b111000, 1, 4'h0);
        cyc("beq_d", 1, 6'b000000, 1, 4'h0);
        cyc("beq_b", 9, 6'b001000, 1, 4'h0);

        // LDR with stalls in FETCH and MEMRD
        Instr = 32'hE5912000;
        for (int i = 0; i < 3; i++) cyc("ldr_fw", 0, 6'b100000, 0, 4'h0);
        cyc("ldr_f",  0, 6'b111000, 1, 4'h0);
        cyc("ldr_d",  1, 6'b000000, 0, 4'h0);
        cyc("ldr_a",  2, 6'b000000, 0, 4'h0);
        for (int i = 0; i < 2; i++) cyc("ldr_rw", 3, 6'b100001, 0, 4'h0);
        cyc("ldr_r",  3, 6'b100001, 1, 4'h0);
        cyc("ldr_wb", 4, 6'b000010, 1, 4'h0);

        // STR stalled in MEMWR, then reset aborts it
        Instr = 32'hE5812000;
        cyc("str_f", 0, 6'b111000, 1, 4'h0);
        cyc("str_d", 1, 6'b000000, 1, 4'h0);
        cyc("str_a", 2, 6'b000000, 1, 4'h0);
        cyc("str_w", 5, 6'b100101, 0, 4'h0);
        #1;
        check("str_pre_mw", 16'(MemWrite), 16'h1);
        reset = 1'b0;
        #1;
        check("rst_async_mw", 16'(MemWrite), 16'h0);
        check("rst_async_st", 16'(state), 16'h0);
        check("rst_async_c", 16'(storedCarry), 16'h0);
        check("rst_async_rw", 16'(RegWrite), 16'h0);
        exp_c = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // CMP updates CV, no register write
        Instr = 32'hE1500001;
        cyc("cmp_f", 0, 6'b111000, 1, 4'h0);
        cyc("cmp_d", 1, 6'b000000, 1, 4'h0);
        cyc("cmp_x", 6, 6'b000000, 1, 4'b1001);
        cyc("cmp_w", 8, 6'b000000, 1, 4'h0);

        // MOVS: NZ load, CV hold (flags become 1001)
        Instr = 32'hE1B00000;
        cyc("movs_f", 0, 6'b111000, 1, 4'h0);
        cyc("movs_d", 1, 6'b000000, 1, 4'h0);
        cyc("movs_x", 6, 6'b000000, 1, 4'b1010);
        cyc("movs_w", 8, 6'b000010, 1, 4'h0);

        // STREQ with Z=0: no write strobe
        Instr = 32'h05812000;
        cyc("streq_f", 0, 6'b111000, 1, 4'h0);
        cyc("streq_d", 1, 6'b000000, 1, 4'h0);
        cyc("streq_a", 2, 6'b000000, 1, 4'h0);
        cyc("streq_w", 5, 6'b100001, 1, 4'h0);

        // MOV PC,LR
        Instr = 32'hE1A0F00E;
        cyc("movpc_f", 0, 6'b111000, 1, 4'h0);
        cyc("movpc_d", 1, 6'b000000, 1, 4'h0);
        cyc("movpc_x", 6, 6'b000000, 1, 4'h0);
        cyc("movpc_w", 8, 6'b001010, 1, 4'h0);
        cyc("end_f",   0, 6'b111000, 1, 4'h0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_controller.md
Name: arm_multicycle_controller

Overview:
- Multicycle successor to the single-cycle ARM controller.
- Sequences each instruction through a Moore FSM: fetch, decode, then execute/memory/writeback.
- Holds NZCV flags and the latched condition result internally, and stalls on a memory ready handshake.
- Sits between the instruction register / ALU flags of the shared-memory datapath and all datapath mux and enable controls.

Parameters:
- ALUCTRL_W, 4, ALUControl width. For DP instructions ALUControl = zero-extended Funct[4:1].
- MEM_HANDSHAKE, 1, 1 = wait in memory states until mem_ready. 0 = mem_ready is ignored and treated as 1.
- FLAGS_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  IR contents; [31:28] cond, [27:26] op, [25:20] funct, [15:12] Rd.
- ALUFlags  in  4  NZCV from the ALU, valid in the EXEC states.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access requested (FETCH, MEMRD, MEMWR).
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- AdrSrc  out  1  0 = PC, 1 = ALU result as memory address.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- RegSrc  out  2  register address selects.
- ImmSrc  out  2  extend select; equals op.
- ALUSrcA  out  1  1 = PC.
- ALUSrcB  out  2  00 reg, 01 imm, 10 const 4.
- ResultSrc  out  2  00 ALUOut, 01 data, 10 ALU direct.
- ALUControl  out  ALUCTRL_W  ALU operation.
- storedCarry  out  1  stored C flag.
- state  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Codes 10-15 are illegal and go to FETCH on the next clock.
- Reset (async, reset=0):
  - state = FETCH, flags = FLAGS_RESET, cond_q = 0.
  - Outputs follow the FETCH decode. All write strobes (MemWrite, RegWrite) are 0 except IRWrite/PCWrite, which track mem_ready.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD(0100), ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay while mem_ready=0, else go to DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ADD (PC+8 for reads).
  - RegSrc = {op==01, op==10}.
  - Latch cond_q = CondEx(Instr[31:28], flags).
  - Next state: op=01 goes to MEMADR. op=10 goes to BRANCH. op=00 goes to EXECI if funct[5], else EXECR. op=11 goes to FETCH.
- MEMADR:
  - ALUSrcB=01, ADD.
  - Next: MEMRD if funct[0] (L), else MEMWR.
- MEMRD:
  - mem_req=1, AdrSrc=1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWR:
  - mem_req=1, AdrSrc=1, MemWrite = cond_q.
  - MemWrite is held for every cycle in the state.
  - Wait for mem_ready, then go to FETCH.
- MEMWB:
  - ResultSrc=01, RegWrite = cond_q.
  - If Rd=15, PCWrite = cond_q.
  - Next: FETCH.
- EXECR / EXECI:
  - ALUSrcB = 00 / 01, ALUControl = Funct[4:1].
  - Flag update at the clock edge when funct[0]=1 and cond_q=1:
    - NZ always load from ALUFlags.
    - CV load only for arithmetic cmds (0010, 0011, 0100, 0101, 0110, 0111, 1010, 1011).
    - Otherwise CV hold.
  - Next: ALUWB.
- ALUWB:
  - ResultSrc=00.
  - RegWrite = cond_q AND cmd not in {1000, 1001, 1010, 1011} (TST/TEQ/CMP/CMN).
  - PCWrite = RegWrite AND Rd==15.
  - Next: FETCH.
- BRANCH:
  - ALUSrcB=01, ADD, ResultSrc=10, PCWrite = cond_q.
  - Next: FETCH.
- CondEx uses standard ARM semantics:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE.
  - AL=1110 gives 1; 1111 gives 1.
- Conditional execution uses only cond_q, latched in DECODE. A flag update in EXEC never affects the same instruction's writeback.
- storedCarry = flags[1] (C) registered, not ALUFlags.
- Reset asserted mid-instruction: aborts immediately, no partial write strobe after the reset edge.
- With MEM_HANDSHAKE=0, each memory state lasts exactly 1 cycle. Latencies:
  - DP: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.

Test Plan:
- Reset low, then high with mem_ready=1 and Instr=E2810001 (ADD R0,R1,#1) -> states 0,1,7,8,0. RegWrite=1 only in ALUWB. ALUControl=0100 in EXECI. Flags stay 0000.
- Instr=E2500001 (SUBS), ALUFlags=0110 in EXECI -> flags=0110, storedCarry=1 from the next cycle. Then Instr=0A000002 (BEQ) -> PCWrite=1 in BRANCH.
- Flags Z=0, Instr=05812000 (STREQ) -> MEMWR reached with MemWrite=0 throughout. No flag change.
- MEM_HANDSHAKE=1, LDR E5912000, mem_ready held 0 for 3 cycles in FETCH and 2 in MEMRD -> IRWrite/PCWrite only on the ready cycle. Total 10 cycles. RegWrite pulses once in MEMWB.
- Instr=E1500001 (CMP) -> RegWrite=0 in ALUWB, CV updated. Instr=E1A0F00E (MOV PC,LR) -> PCWrite=1 and RegWrite=1 in ALUWB.
- Reset pulled low during MEMWR with MemWrite=1 -> MemWrite=0 asynchronously, state=0, flags=FLAGS_RESET.
